// File: rtl/contact_collector.sv
// Sphere-pair contact collector: launches one collider operation per accepted pair and
// queues hit results in a small FIFO for a downstream consumer.
module contact_collector #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pair_valid,
  output logic        pair_ready,
  input  logic [95:0] in_p1,
  input  logic [95:0] in_p2,
  input  logic [31:0] in_r1,
  input  logic [31:0] in_r2,
  input  logic [31:0] in_g1,
  input  logic [31:0] in_g2,
  output logic        col_start,
  output logic [95:0] col_p1,
  output logic [31:0] col_r1,
  output logic [95:0] col_p2,
  output logic [31:0] col_r2,
  input  logic        col_done,
  input  logic        col_ret,
  input  logic [95:0] col_pos,
  input  logic [95:0] col_normal,
  input  logic [31:0] col_depth,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [95:0] ct_pos,
  output logic [95:0] ct_normal,
  output logic [31:0] ct_depth,
  output logic [31:0] ct_g1,
  output logic [31:0] ct_g2,
  output logic        busy,
  output logic [15:0] contact_count,
  output logic [15:0] miss_count,
  output logic        timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = 288;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StStore} state_e;

  state_e          state_q, state_d;
  logic            done_prev_q;
  logic            col_start_q;
  logic [95:0]     col_p1_q, col_p2_q;
  logic [31:0]     col_r1_q, col_r2_q, g1_q, g2_q;
  logic            ret_q;
  logic [95:0]     pos_q, normal_q;
  logic [31:0]     depth_q;
  logic [TW-1:0]   tmo_q;
  logic            timeout_err_q;
  logic [15:0]     contact_cnt_q, miss_cnt_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;

  logic accept, done_edge, push, pop, capture, tmo_hit, full;

  assign full       = (count_q == CW'(DEPTH));
  // Reset gates ready directly so nothing is offered while rst is held low.
  assign pair_ready = rst && (state_q == StIdle) && !full;
  assign accept     = pair_valid && pair_ready;
  assign done_edge  = col_done && !done_prev_q;
  assign push       = (state_q == StStore) && ret_q;
  assign ct_valid   = (count_q != '0);
  assign pop        = ct_valid && ct_ready;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait: begin
        if (done_edge) begin
          state_d = StStore;
          capture = 1'b1;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          tmo_hit = 1'b1;
        end
      end
      StStore:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      done_prev_q   <= 1'b0;
      col_start_q   <= 1'b0;
      col_p1_q      <= '0;
      col_p2_q      <= '0;
      col_r1_q      <= '0;
      col_r2_q      <= '0;
      g1_q          <= '0;
      g2_q          <= '0;
      ret_q         <= 1'b0;
      pos_q         <= '0;
      normal_q      <= '0;
      depth_q       <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      contact_cnt_q <= '0;
      miss_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= col_done;
      col_start_q <= accept;
      if (accept) begin
        col_p1_q <= in_p1;
        col_p2_q <= in_p2;
        col_r1_q <= in_r1;
        col_r2_q <= in_r2;
        g1_q     <= in_g1;
        g2_q     <= in_g2;
      end
      if (state_q == StLaunch) tmo_q <= '0;
      else if (state_q == StWait) tmo_q <= tmo_q + TW'(1);
      if (capture) begin
        ret_q    <= col_ret;
        pos_q    <= col_pos;
        normal_q <= col_normal;
        depth_q  <= col_depth;
      end
      if (tmo_hit) timeout_err_q <= 1'b1;
      if (state_q == StStore) begin
        if (ret_q) begin
          if (contact_cnt_q != 16'hFFFF) contact_cnt_q <= contact_cnt_q + 16'd1;
        end else if (miss_cnt_q != 16'hFFFF) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pos_q, normal_q, depth_q, g1_q, g2_q};
  end

  assign head          = mem_q[rd_ptr_q];
  assign ct_pos        = head[287:192];
  assign ct_normal     = head[191:96];
  assign ct_depth      = head[95:64];
  assign ct_g1         = head[63:32];
  assign ct_g2         = head[31:0];
  assign col_start     = col_start_q;
  assign col_p1        = col_p1_q;
  assign col_r1        = col_r1_q;
  assign col_p2        = col_p2_q;
  assign col_r2        = col_r2_q;
  assign busy          = (state_q != StIdle);
  assign contact_count = contact_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_contact_collector.sv
// Directed scoreboard bench for contact_collector: hit, miss, backpressure, stale done,
// timeout and reset-in-WAIT scenarios.
module tb_contact_collector;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pair_valid = 1'b0, pair_ready;
  logic [95:0] in_p1 = '0, in_p2 = '0;
  logic [31:0] in_r1 = '0, in_r2 = '0, in_g1 = '0, in_g2 = '0;
  logic        col_start;
  logic [95:0] col_p1, col_p2;
  logic [31:0] col_r1, col_r2;
  logic        col_done = 1'b0, col_ret = 1'b0;
  logic [95:0] col_pos = '0, col_normal = '0;
  logic [31:0] col_depth = '0;
  logic        ct_valid, ct_ready = 1'b0;
  logic [95:0] ct_pos, ct_normal;
  logic [31:0] ct_depth, ct_g1, ct_g2;
  logic        busy, timeout_err;
  logic [15:0] contact_count, miss_count;

  contact_collector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_r1(in_r1), .in_r2(in_r2), .in_g1(in_g1), .in_g2(in_g2),
    .col_start(col_start), .col_p1(col_p1), .col_r1(col_r1), .col_p2(col_p2), .col_r2(col_r2),
    .col_done(col_done), .col_ret(col_ret), .col_pos(col_pos), .col_normal(col_normal),
    .col_depth(col_depth), .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_pos(ct_pos),
    .ct_normal(ct_normal), .ct_depth(ct_depth), .ct_g1(ct_g1), .ct_g2(ct_g2), .busy(busy),
    .contact_count(contact_count), .miss_count(miss_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            exp_hit = 0;
  int            exp_miss = 0;
  logic [287:0]  sb[$];

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers a pair, waits for acceptance, checks the launch cycle; returns in first WAIT cycle.
  task automatic accept_pair(input logic [95:0] p1, input logic [31:0] r1,
                             input logic [95:0] p2, input logic [31:0] r2,
                             input logic [31:0] g1, input logic [31:0] g2);
    int t = 0;
    pair_valid = 1'b1;
    in_p1 = p1; in_r1 = r1; in_p2 = p2; in_r2 = r2; in_g1 = g1; in_g2 = g2;
    while (!pair_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", pair_ready, 1'b1);
    @(negedge clk);
    pair_valid = 1'b0;
    in_p1 = '0; in_p2 = '0; in_r1 = '0; in_r2 = '0; in_g1 = '0; in_g2 = '0;
    check("col_start", col_start, 1'b1);
    check("col_operands", {col_p1, col_r1, col_p2, col_r2}, {p1, r1, p2, r2});
    check("busy_launch", busy, 1'b1);
    @(negedge clk);
    check("col_start_pulse", col_start, 1'b0);
  endtask

  // Raises col_done for one cycle from a WAIT cycle; returns in the IDLE cycle after STORE.
  task automatic respond(input bit ret, input logic [95:0] pos, input logic [95:0] nrm,
                         input logic [31:0] dep, input logic [31:0] g1, input logic [31:0] g2);
    col_done = 1'b1; col_ret = ret; col_pos = pos; col_normal = nrm; col_depth = dep;
    @(negedge clk);
    col_done = 1'b0; col_ret = 1'b0; col_pos = '0; col_normal = '0; col_depth = '0;
    check("busy_store", busy, 1'b1);
    check("ct_valid_store", ct_valid, sb.size() != 0);
    if (ret) begin
      sb.push_back({pos, nrm, dep, g1, g2});
      exp_hit++;
    end else begin
      exp_miss++;
    end
    @(negedge clk);
    check("busy_idle", busy, 1'b0);
    check("contact_count", contact_count, 16'(exp_hit));
    check("miss_count", miss_count, 16'(exp_miss));
  endtask

  task automatic pop_head();
    logic [287:0] exp = '0;
    check("ct_valid_head", ct_valid, 1'b1);
    if (sb.size() != 0) exp = sb.pop_front();
    check("ct_entry", {ct_pos, ct_normal, ct_depth, ct_g1, ct_g2}, exp);
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(2);
    check("rst_pair_ready", pair_ready, 1'b0);
    check("rst_ct_valid", ct_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_regs", {col_start, timeout_err, contact_count, miss_count, col_p1}, '0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", pair_ready, 1'b1);

    // Hit
    accept_pair(96'h0, 32'h3F800000, {32'h3F800000, 64'h0}, 32'h3F800000, 32'h11, 32'h22);
    respond(1'b1, {32'h3F000000, 64'h0}, {32'h3F800000, 64'h0}, 32'h3F800000, 32'h11, 32'h22);
    pop_head();
    check("ct_valid_drained", ct_valid, 1'b0);

    // Miss
    accept_pair({3{32'h40000000}}, 32'h1, 96'h0, 32'h1, 32'h33, 32'h44);
    respond(1'b0, {3{32'hDEAD0000}}, '1, 32'h5, 32'h33, 32'h44);
    check("ready_after_miss", pair_ready, 1'b1);
    check("ct_valid_miss", ct_valid, 1'b0);

    // Backpressure: fill all DEPTH entries with no consumer
    for (int i = 1; i <= 4; i++) begin
      accept_pair({3{32'(i)}}, 32'(i), {3{32'(i + 16)}}, 32'(i + 16), 32'(i), 32'(i + 8));
      respond(1'b1, {3{32'(i * 3)}}, {3{32'(i * 5)}}, 32'(i * 7), 32'(i), 32'(i + 8));
    end
    check("ready_full", pair_ready, 1'b0);
    pop_head();
    check("ready_after_pop", pair_ready, 1'b1);
    repeat (3) pop_head();
    check("ct_valid_empty", ct_valid, 1'b0);

    // Stale done level held across the launch
    col_done = 1'b1;
    accept_pair({3{32'hA}}, 32'hB, {3{32'hC}}, 32'hD, 32'h55, 32'h66);
    tick(3);
    check("stale_busy", busy, 1'b1);
    check("stale_count", contact_count, 16'(exp_hit));
    col_done = 1'b0;
    @(negedge clk);
    respond(1'b1, {3{32'h77}}, {3{32'h88}}, 32'h99, 32'h55, 32'h66);
    pop_head();

    // Timeout: collider never answers
    accept_pair({3{32'h1}}, 32'h2, {3{32'h3}}, 32'h4, 32'h5, 32'h6);
    tick(TIMEOUT - 1);
    check("tmo_last_wait_busy", busy, 1'b1);
    check("tmo_not_yet", timeout_err, 1'b0);
    @(negedge clk);
    check("tmo_idle", busy, 1'b0);
    check("tmo_err", timeout_err, 1'b1);
    check("tmo_counts", {contact_count, miss_count}, {16'(exp_hit), 16'(exp_miss)});
    check("tmo_no_entry", ct_valid, 1'b0);

    // Reset during WAIT, then a late done edge
    accept_pair({3{32'h7}}, 32'h8, {3{32'h9}}, 32'hA, 32'hB, 32'hC);
    rst = 1'b0;
    #1;
    check("rstw_busy", busy, 1'b0);
    check("rstw_ready", pair_ready, 1'b0);
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk);
    rst = 1'b1;
    col_done = 1'b1; col_ret = 1'b1;
    @(negedge clk);
    col_done = 1'b0; col_ret = 1'b0;
    tick(3);
    check("rstw_state", {ct_valid, busy, timeout_err}, 3'b000);
    check("rstw_counts", {contact_count, miss_count}, 32'h0);

    // Normal operation resumes after reset
    accept_pair({3{32'hF}}, 32'hE, {3{32'hD}}, 32'hC, 32'hAB, 32'hCD);
    respond(1'b1, {3{32'h12}}, {3{32'h34}}, 32'h56, 32'hAB, 32'hCD);
    pop_head();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/contact_collector.md
CONTACT_COLLECTOR -- requirements
Module: contact_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4: contact FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum WAIT cycles before abort.
REQ-003 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pair_valid, input, 1: sphere pair offered.
REQ-006 SHALL have port pair_ready, output, 1: pair accepted when pair_valid and pair_ready are both high.
REQ-007 SHALL have ports in_p1, in_p2, input, 96 each: centres {x,y,z}, IEEE-754 single, x at [95:64].
REQ-008 SHALL have ports in_r1, in_r2, in_g1, in_g2, input, 32 each: radii and geom IDs.
REQ-009 SHALL have port col_start, output, 1: one-cycle launch pulse to the collider.
REQ-010 SHALL have ports col_p1, col_r1, col_p2, col_r2, output, 96/32/96/32: latched operands to the collider.
REQ-011 SHALL have ports col_done, col_ret, input, 1 each: collider completion and contact flag.
REQ-012 SHALL have ports col_pos, col_normal, col_depth, input, 96/96/32: collider results.
REQ-013 SHALL have port ct_valid, output, 1: a contact entry is available.
REQ-014 SHALL have port ct_ready, input, 1: the consumer accepts the head entry.
REQ-015 SHALL have ports ct_pos, ct_normal, ct_depth, ct_g1, ct_g2, output, 96/96/32/32/32: head entry fields.
REQ-016 SHALL have ports busy, output, 1 (state not IDLE); contact_count and miss_count, output, 16 each; timeout_err, output, 1.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, LAUNCH, WAIT, STORE.
REQ-018 SHALL drive pair_ready high only in IDLE and only when FIFO occupancy is below DEPTH, reserving the slot for the launched pair.
REQ-019 SHALL, on acceptance in IDLE, latch all pair fields into col_* and internal g1/g2 registers and enter LAUNCH.
REQ-020 SHALL hold the col_* outputs stable from acceptance until the FSM returns to IDLE.
REQ-021 SHALL assert col_start for exactly one cycle in LAUNCH, then enter WAIT with the timeout counter cleared.
REQ-022 SHALL, in WAIT, detect completion only on a rising edge of col_done (col_done high, registered previous sample low); a level held over from a prior operation SHALL be ignored.
REQ-023 SHALL, on a detected rising edge, capture col_ret, col_pos, col_normal and col_depth and enter STORE.
REQ-024 SHALL, in STORE with captured ret=1, push {pos, normal, depth, g1, g2} into the FIFO, increment contact_count, and return to IDLE.
REQ-025 SHALL, in STORE with captured ret=0, push nothing, increment miss_count, and return to IDLE.
REQ-026 SHALL saturate contact_count and miss_count at 0xFFFF.
REQ-027 SHALL, when the WAIT counter reaches TIMEOUT-1 with no edge, set timeout_err (sticky until reset), push nothing, change neither count, and return to IDLE.
REQ-028 SHALL give a minimum latency of 4 cycles from acceptance to ct_valid when the collider answers in the first WAIT cycle; STORE pushes on its clock edge.
REQ-029 SHALL drive ct_valid = FIFO not empty, with the ct_* fields presenting the head entry combinationally from the read pointer.
REQ-030 SHALL pop the head entry when ct_valid and ct_ready are both high.
REQ-031 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged; pointers wrap modulo DEPTH.
REQ-032 SHALL never push when full (guaranteed by REQ-018) and SHALL ignore ct_ready when empty.

Reset
REQ-033 SHALL, on rst low, asynchronously enter IDLE and clear FIFO pointers, occupancy, counters, timeout_err, col_start, all col_* registers, and the registered col_done sample.
REQ-034 SHALL, with rst low, drive pair_ready=0, ct_valid=0 and busy=0; pair_ready rises the first cycle after release.
REQ-035 SHALL, on reset during WAIT, produce no push and no count change, and ignore any later col_done edge until a new launch.

Verification
REQ-036 Hit: pair p1=(0,0,0), r1=0x3F800000, p2=(0x3F800000,0,0), r2=0x3F800000, g1=0x11, g2=0x22; collider returns done/ret=1, pos=(0x3F000000,0,0), depth=0x3F800000 -> one col_start pulse, ct_valid after 4 cycles with those values, contact_count=1.
REQ-037 Miss: col_ret=0 on done -> ct_valid stays 0, miss_count=1, pair_ready high again the cycle after STORE.
REQ-038 Backpressure: DEPTH=4 hits with ct_ready=0 -> pair_ready low after the 4th acceptance; one pop -> pair_ready high next cycle; entries drain in order of g1.
REQ-039 Stale done: col_done held high from before the launch -> no completion until col_done falls and rises again.
REQ-040 Timeout: TIMEOUT=16, col_done never rises -> timeout_err=1 after 16 WAIT cycles, FSM in IDLE, counts unchanged.
REQ-041 Reset in WAIT, then col_done rises -> no entry, counts 0, busy=0.
